// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment scanner for a packed BCD snapshot: one digit lit per refresh slot,
// optional leading-zero blanking, '-' and an error flag for non-decimal nibbles.
module bcd_display_scan #(
    parameter int DIGITS     = 11,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  err
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                state_r;
    logic [4*DIGITS-1:0]   snapshot_r;
    logic [DIV_W-1:0]      div_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  err_r;
    logic [6:0]            seg_r;
    logic [DIGITS-1:0]     an_r;

    logic [3:0]            nib_s;
    logic                  zero_run_s;
    logic                  hidden_s;
    logic                  lit_s;
    logic [DIGITS-1:0]     an_hot_s;
    logic [6:0]            seg_s;
    logic [DIGITS-1:0]     an_s;

    function automatic logic [6:0] decode7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    function automatic logic any_invalid(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // Select the current digit and decide whether it sits inside the run of leading zeros.
    always_comb begin
        nib_s      = 4'd0;
        hidden_s   = 1'b0;
        zero_run_s = 1'b1;
        an_hot_s   = {DIGITS{1'b0}};
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run_s  = zero_run_s && (snapshot_r[4*k +: 4] == 4'd0);
            an_hot_s[k] = (idx_r == IDX_W'(k));
            if (idx_r == IDX_W'(k)) begin
                nib_s    = snapshot_r[4*k +: 4];
                hidden_s = zero_run_s;
            end else begin
                nib_s    = nib_s;
                hidden_s = hidden_s;
            end
        end
        lit_s = (state_r == SCAN) && !(blank_lz && (idx_r != {IDX_W{1'b0}}) && hidden_s);
        if (lit_s) begin
            seg_s = decode7(nib_s);
            an_s  = an_hot_s;
        end else begin
            seg_s = 7'h00;
            an_s  = {DIGITS{1'b0}};
        end
    end

    // Refresh counters, snapshot capture and registered display drive.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= IDLE;
            snapshot_r <= {(4*DIGITS){1'b0}};
            div_r      <= {DIV_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            err_r      <= 1'b0;
            seg_r      <= {7{POL}};
            an_r       <= {DIGITS{POL}};
        end else begin
            if (div_r == DIV_LAST) begin
                div_r <= {DIV_W{1'b0}};
                idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end
            if (load) begin
                snapshot_r <= bcd_in;
                state_r    <= SCAN;
                err_r      <= any_invalid(bcd_in);
            end
            seg_r <= seg_s ^ {7{POL}};
            an_r  <= an_s ^ {DIGITS{POL}};
        end
    end

    assign seg = seg_r;
    assign an  = an_r;
    assign err = err_r;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomised and directed bench for bcd_display_scan: an active-high and an active-low
// instance share stimulus and are checked against a cycle-count reference model.
module tb_bcd_display_scan;

    localparam int D  = 11;
    localparam int SD = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [43:0] bcd_in = 44'h0;
    logic [6:0]  seg_h, seg_l;
    logic [10:0] an_h, an_l;
    logic        err_h, err_l;

    int checks = 0;
    int errors = 0;

    logic [3:0]  m_dig [D];
    bit          m_valid;
    bit          m_err;
    int          m_t;
    logic [6:0]  exp_seg;
    logic [10:0] exp_an;
    logic        exp_err;
    int          exp_idx;
    logic [6:0]  dec_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_display_scan #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(0)) dut_h (
        .Clk(Clk), .Reset_n(Reset_n), .load(load), .bcd_in(bcd_in), .blank_lz(blank_lz),
        .seg(seg_h), .an(an_h), .err(err_h));

    bcd_display_scan #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(1)) dut_l (
        .Clk(Clk), .Reset_n(Reset_n), .load(load), .bcd_in(bcd_in), .blank_lz(blank_lz),
        .seg(seg_l), .an(an_l), .err(err_l));

    always #5 Clk = ~Clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        if (n < 4'd10) return dec_tab[n];
        return 7'h40;
    endfunction

    function automatic logic [43:0] rand_bcd();
        logic [43:0] v;
        int nz;
        v  = 44'h0;
        nz = $urandom_range(0, D);
        for (int k = 0; k < nz; k++) begin
            if ($urandom_range(0, 9) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
            else                           v[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_t     = 0;
        for (int k = 0; k < D; k++) m_dig[k] = 4'd0;
        exp_seg = 7'h00;
        exp_an  = 11'h000;
        exp_err = 1'b0;
        exp_idx = 0;
    endtask

    // One clock edge: the slot shown is the one the scan sat in just before the edge.
    task automatic tick();
        int  idx;
        bit  hidden;
        bit  lit;
        @(posedge Clk);
        if (!Reset_n) begin
            model_clear();
        end else begin
            idx    = (m_t / SD) % D;
            hidden = 1'b1;
            for (int k = idx; k < D; k++) if (m_dig[k] != 4'd0) hidden = 1'b0;
            lit     = m_valid && !(blank_lz && idx != 0 && hidden);
            exp_idx = idx;
            exp_seg = lit ? ref_seg(m_dig[idx]) : 7'h00;
            exp_an  = lit ? (11'd1 << idx) : 11'd0;
            if (load) begin
                m_valid = 1'b1;
                m_err   = 1'b0;
                for (int k = 0; k < D; k++) begin
                    m_dig[k] = bcd_in[4*k +: 4];
                    if (bcd_in[4*k +: 4] > 4'd9) m_err = 1'b1;
                end
            end
            exp_err = m_err;
            m_t++;
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({seg_h, an_h, err_h} !== {7'h00, 11'h000, 1'b0}) begin
            errors++;
            $display("FAIL reset_hi got seg=%h an=%h err=%b want 00 000 0", seg_h, an_h, err_h);
        end
        checks++;
        if ({seg_l, an_l, err_l} !== {7'h7F, 11'h7FF, 1'b0}) begin
            errors++;
            $display("FAIL reset_lo got seg=%h an=%h err=%b want 7f 7ff 0", seg_l, an_l, err_l);
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({seg_h, an_h} !== 18'h0) begin
                errors++;
                $display("FAIL idle_dark cyc=%0d got seg=%h an=%h want 00 000", i, seg_h, an_h);
            end
        end
    endtask

    task automatic test_digits();
        logic [6:0] want [D] = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        blank_lz = 1'b1;
        bcd_in   = 44'h0000_0001234;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * SD * D; i++) begin
            tick();
            checks++;
            if ({seg_h, an_h, err_h} !== {exp_seg, exp_an, exp_err}) begin
                errors++;
                $display("FAIL digits_model idx=%0d got %h/%h/%b want %h/%h/%b", exp_idx, seg_h, an_h, err_h, exp_seg, exp_an, exp_err);
            end
            checks++;
            if (seg_h !== want[exp_idx] || an_h !== ((exp_idx < 4) ? (11'd1 << exp_idx) : 11'd0)) begin
                errors++;
                $display("FAIL digits_table idx=%0d got seg=%h an=%h want seg=%h", exp_idx, seg_h, an_h, want[exp_idx]);
            end
        end
    endtask

    task automatic test_zero();
        blank_lz = 1'b0;
        bcd_in   = 44'h0;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * SD * D; i++) begin
            tick();
            checks++;
            if (seg_h !== 7'h3F || an_h !== (11'd1 << exp_idx) || an_h !== exp_an) begin
                errors++;
                $display("FAIL zero_walk idx=%0d got seg=%h an=%h want 3f %h", exp_idx, seg_h, an_h, exp_an);
            end
        end
        blank_lz = 1'b1;
        for (int i = 0; i < SD * D; i++) begin
            tick();
            checks++;
            if ({seg_h, an_h} !== ((exp_idx == 0) ? {7'h3F, 11'h001} : 18'h0)) begin
                errors++;
                $display("FAIL zero_blank idx=%0d got seg=%h an=%h", exp_idx, seg_h, an_h);
            end
        end
    endtask

    task automatic test_invalid();
        blank_lz = 1'b1;
        bcd_in   = 44'h0000_0000A00;
        load     = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (err_h !== 1'b1 || err_l !== 1'b1) begin
            errors++;
            $display("FAIL invalid_err got %b/%b want 1", err_h, err_l);
        end
        for (int i = 0; i < SD * D + 2; i++) begin
            tick();
            checks++;
            if ({seg_h, an_h, err_h} !== {exp_seg, exp_an, exp_err}) begin
                errors++;
                $display("FAIL invalid_model idx=%0d got %h/%h/%b want %h/%h/%b", exp_idx, seg_h, an_h, err_h, exp_seg, exp_an, exp_err);
            end
            if (exp_idx == 2 || exp_idx == 1) begin
                checks++;
                if (seg_h !== ((exp_idx == 2) ? 7'h40 : 7'h3F) || an_h !== (11'd1 << exp_idx)) begin
                    errors++;
                    $display("FAIL invalid_slot idx=%0d got seg=%h an=%h", exp_idx, seg_h, an_h);
                end
            end
        end
        bcd_in = 44'h5;
        load   = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (err_h !== 1'b0 || err_l !== 1'b0) begin
            errors++;
            $display("FAIL invalid_clear got %b/%b want 0", err_h, err_l);
        end
    endtask

    task automatic test_coincide();
        logic [43:0] v;
        blank_lz = 1'b0;
        for (int i = 0; i < SD * D && (m_t % (SD * D)) != 5 * SD + SD - 1; i++) tick();
        v = 44'h9876543210_1;
        bcd_in = v;
        load   = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (an_h !== 11'h040 || seg_h !== ref_seg(v[27:24])) begin
            errors++;
            $display("FAIL coincide got seg=%h an=%h want %h 040", seg_h, an_h, ref_seg(v[27:24]));
        end
        for (int i = 0; i < 3 * SD; i++) begin
            tick();
            checks++;
            if ({seg_h, an_h} !== {exp_seg, exp_an}) begin
                errors++;
                $display("FAIL coincide_run idx=%0d got %h/%h want %h/%h", exp_idx, seg_h, an_h, exp_seg, exp_an);
            end
        end
    endtask

    task automatic test_active_low();
        blank_lz = 1'b1;
        bcd_in   = 44'h0000_0001234;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < SD * D; i++) begin
            tick();
            checks++;
            if ({seg_l, an_l, err_l} !== {~exp_seg, ~exp_an, exp_err}) begin
                errors++;
                $display("FAIL lo_model idx=%0d got %h/%h/%b want %h/%h/%b", exp_idx, seg_l, an_l, err_l, ~exp_seg, ~exp_an, exp_err);
            end
            if (exp_idx == 0 || exp_idx >= 4) begin
                checks++;
                if ({seg_l, an_l} !== ((exp_idx == 0) ? {7'h19, 11'h7FE} : {7'h7F, 11'h7FF})) begin
                    errors++;
                    $display("FAIL lo_slot idx=%0d got seg=%h an=%h", exp_idx, seg_l, an_l);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({seg_h, an_h, err_h, seg_l, an_l, err_l} !== {7'h00, 11'h000, 1'b0, 7'h7F, 11'h7FF, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got %h/%h/%b %h/%h/%b", seg_h, an_h, err_h, seg_l, an_l, err_l);
        end
        model_clear();
        tick();
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({seg_h, an_h, err_h} !== 19'h0) begin
                errors++;
                $display("FAIL reset_dark cyc=%0d got %h/%h/%b", i, seg_h, an_h, err_h);
            end
        end
        blank_lz = 1'b0;
        bcd_in   = 44'h0000_0000007;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < SD * D; i++) begin
            tick();
            checks++;
            if ({seg_h, an_h} !== {exp_seg, exp_an}) begin
                errors++;
                $display("FAIL reset_restart idx=%0d got %h/%h want %h/%h", exp_idx, seg_h, an_h, exp_seg, exp_an);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            load   = ($urandom_range(0, 15) == 0);
            bcd_in = rand_bcd();
            tick();
            checks++;
            if ({seg_h, an_h, err_h} !== {exp_seg, exp_an, exp_err}) begin
                errors++;
                $display("FAIL rand_hi cyc=%0d got %h/%h/%b want %h/%h/%b", i, seg_h, an_h, err_h, exp_seg, exp_an, exp_err);
            end
            checks++;
            if ({seg_l, an_l, err_l} !== {~exp_seg, ~exp_an, exp_err}) begin
                errors++;
                $display("FAIL rand_lo cyc=%0d got %h/%h/%b want %h/%h/%b", i, seg_l, an_l, err_l, ~exp_seg, ~exp_an, exp_err);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_digits();
        test_zero();
        test_invalid();
        test_coincide();
        test_active_low();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
